u14_cpu: RTL and testbench

- Multi-cycle 8-bit accumulator CPU with 6502-style encodings; next generation of the u13 core.
- Adds ALU ops, absolute/zero-page/immediate modes on every memory op, conditional branches, flags, a memory wait handshake (rdy) and split data buses.
- Single-master memory bus toward the system RAM/ROM decoder; sync marks opcode fetch cycles for the debug tracer.

---
 rtl/u14_pkg.sv | 102 ++++++++++
 rtl/u14_if.sv | 35 +++
 rtl/u14_alu.sv | 37 +++
 rtl/u14_cpu.sv | 171 +++++++++++++++++
 tb/tb_u14_cpu.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/u14_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : u14_pkg
//  Brief    : Opcodes, FSM/ALU/addressing enums and instruction decode for u14.
//  Revision : 1.0
// ============================================================================
package u14_pkg;

    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_BCC     = 8'h90;
    localparam logic [7:0] OP_BCS     = 8'hB0;
    localparam logic [7:0] OP_BNE     = 8'hD0;
    localparam logic [7:0] OP_BEQ     = 8'hF0;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        ABS_HI = 2'd2,
        EXEC   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_PASS = 3'd5
    } alu_op_t;

    typedef enum logic [2:0] {
        MODE_IMP = 3'd0,
        MODE_IMM = 3'd1,
        MODE_ZP  = 3'd2,
        MODE_ABS = 3'd3,
        MODE_REL = 3'd4
    } mode_t;

    typedef struct packed {
        mode_t   mode;
        alu_op_t alu;
        logic    wr_a;
        logic    is_store;
        logic    is_jmp;
        logic    br_on_z;
        logic    br_val;
        logic    set_c;
        logic    clr_c;
    } dec_t;

    function automatic dec_t decode(input logic [7:0] op);
        dec_t d;
        d      = '0;
        d.mode = MODE_IMP;
        d.alu  = ALU_PASS;
        // Memory-op group: low five bits select the mode, top three the operation.
        if (op[4:0] == 5'h09 || op[4:0] == 5'h05 || op[4:0] == 5'h0D) begin
            d.wr_a = 1'b1;
            case (op[7:5])
                3'b000:  d.alu = ALU_OR;
                3'b001:  d.alu = ALU_AND;
                3'b010:  d.alu = ALU_XOR;
                3'b011:  d.alu = ALU_ADD;
                3'b101:  d.alu = ALU_PASS;
                3'b111:  d.alu = ALU_SUB;
                3'b100: begin
                    d.wr_a     = 1'b0;
                    d.is_store = (op[4:0] != 5'h09);
                end
                default: d.wr_a = 1'b0;
            endcase
            if (d.wr_a || d.is_store) begin
                case (op[4:0])
                    5'h09:   d.mode = MODE_IMM;
                    5'h05:   d.mode = MODE_ZP;
                    default: d.mode = MODE_ABS;
                endcase
            end
        end else begin
            case (op)
                OP_JMP_ABS: begin
                    d.mode   = MODE_ABS;
                    d.is_jmp = 1'b1;
                end
                OP_BCC, OP_BCS, OP_BNE, OP_BEQ: begin
                    d.mode    = MODE_REL;
                    d.br_on_z = op[6];
                    d.br_val  = op[5];
                end
                OP_CLC:  d.clr_c = 1'b1;
                OP_SEC:  d.set_c = 1'b1;
                default: d.mode  = MODE_IMP;
            endcase
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/u14_if.sv
`default_nettype none
// ============================================================================
//  Module   : u14_if
//  Brief    : Single-master memory bus between the u14 core and the system.
//  Revision : 1.0
// ============================================================================
interface u14_if #(
    parameter int ADDR_W = 16
);
    logic              rdy;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              sync;

    modport master (
        input  rdy,
        input  data_in,
        output data_out,
        output addr,
        output we,
        output sync
    );

    modport slave (
        output rdy,
        output data_in,
        input  data_out,
        input  addr,
        input  we,
        input  sync
    );
endinterface
`default_nettype wire

// File: rtl/u14_alu.sv
`default_nettype none
// ============================================================================
//  Module   : u14_alu
//  Brief    : Combinational 8-bit ALU; SUB is A + ~B + cin (cin=1 means no borrow).
//  Revision : 1.0
// ============================================================================
module u14_alu
    import u14_pkg::*;
(
    input  alu_op_t    i_op,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_res,
    output logic       o_cout
);
    logic [7:0] w_b;
    logic [8:0] w_sum;

    always_comb begin
        w_b    = (i_op == ALU_SUB) ? ~i_b : i_b;
        w_sum  = {1'b0, i_a} + {1'b0, w_b} + {8'd0, i_cin};
        o_res  = i_b;
        o_cout = i_cin;
        case (i_op)
            ALU_ADD, ALU_SUB: begin
                o_res  = w_sum[7:0];
                o_cout = w_sum[8];
            end
            ALU_AND:  o_res = i_a & i_b;
            ALU_OR:   o_res = i_a | i_b;
            ALU_XOR:  o_res = i_a ^ i_b;
            default:  o_res = i_b;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/u14_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : u14_cpu
//  Brief    : Multi-cycle 8-bit accumulator CPU, 6502-style encodings, rdy stall.
//  Revision : 1.0
// ============================================================================
module u14_cpu
    import u14_pkg::*;
#(
    parameter int          ADDR_W  = 16,
    parameter logic [15:0] RST_VEC = 16'hFFF0
)(
    input  wire        clk,
    input  wire        rst,
    u14_if.master      bus,
    output logic [7:0] a_out,
    output logic [2:0] flags
);
    localparam logic [ADDR_W-1:0] c_rst = RST_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_ir, w_ir_nxt;
    logic [7:0]        r_lo, w_lo_nxt;
    logic [7:0]        r_a, w_a_nxt;
    logic              r_n, w_n_nxt;
    logic              r_z, w_z_nxt;
    logic              r_c, w_c_nxt;
    logic              r_we, w_we_nxt;

    dec_t              w_dec;
    logic              w_exec;
    logic              w_taken;
    logic [7:0]        w_alu_res;
    logic              w_alu_cout;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_zp;
    logic [15:0]       w_abs16;
    logic [ADDR_W-1:0] w_abs;

    assign w_dec    = decode(r_ir);
    assign w_pc_inc = r_pc + c_one;
    assign w_off    = {{(ADDR_W-8){bus.data_in[7]}}, bus.data_in};
    assign w_zp     = {{(ADDR_W-8){1'b0}}, bus.data_in};
    assign w_abs16  = {bus.data_in, r_lo};
    assign w_abs    = w_abs16[ADDR_W-1:0];
    assign w_taken  = w_dec.br_on_z ? (r_z == w_dec.br_val) : (r_c == w_dec.br_val);

    // The operand for both immediate and memory forms is whatever is on data_in.
    u14_alu u_alu (
        .i_op   (w_dec.alu),
        .i_a    (r_a),
        .i_b    (bus.data_in),
        .i_cin  (r_c),
        .o_res  (w_alu_res),
        .o_cout (w_alu_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= c_rst;
            r_addr  <= c_rst;
            r_ir    <= 8'h00;
            r_lo    <= 8'h00;
            r_a     <= 8'h00;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_we    <= 1'b0;
        end else if (bus.rdy) begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_ir    <= w_ir_nxt;
            r_lo    <= w_lo_nxt;
            r_a     <= w_a_nxt;
            r_n     <= w_n_nxt;
            r_z     <= w_z_nxt;
            r_c     <= w_c_nxt;
            r_we    <= w_we_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_ir_nxt    = r_ir;
        w_lo_nxt    = r_lo;
        w_a_nxt     = r_a;
        w_n_nxt     = r_n;
        w_z_nxt     = r_z;
        w_c_nxt     = r_c;
        w_we_nxt    = r_we;
        w_exec      = 1'b0;
        case (r_state)
            FETCH: begin
                w_ir_nxt    = bus.data_in;
                w_pc_nxt    = w_pc_inc;
                w_addr_nxt  = w_pc_inc;
                w_state_nxt = DECODE;
            end
            DECODE: begin
                w_state_nxt = FETCH;
                case (w_dec.mode)
                    MODE_IMM: begin
                        w_exec     = w_dec.wr_a;
                        w_pc_nxt   = w_pc_inc;
                        w_addr_nxt = w_pc_inc;
                    end
                    MODE_ZP: begin
                        w_addr_nxt  = w_zp;
                        w_pc_nxt    = w_pc_inc;
                        w_we_nxt    = w_dec.is_store;
                        w_state_nxt = EXEC;
                    end
                    MODE_ABS: begin
                        w_lo_nxt    = bus.data_in;
                        w_pc_nxt    = w_pc_inc;
                        w_addr_nxt  = w_pc_inc;
                        w_state_nxt = ABS_HI;
                    end
                    MODE_REL: begin
                        w_pc_nxt   = w_taken ? (w_pc_inc + w_off) : w_pc_inc;
                        w_addr_nxt = w_pc_nxt;
                    end
                    default: begin
                        if (w_dec.set_c) w_c_nxt = 1'b1;
                        if (w_dec.clr_c) w_c_nxt = 1'b0;
                    end
                endcase
            end
            ABS_HI: begin
                if (w_dec.is_jmp) begin
                    w_pc_nxt    = w_abs;
                    w_addr_nxt  = w_abs;
                    w_state_nxt = FETCH;
                end else begin
                    w_addr_nxt  = w_abs;
                    w_pc_nxt    = w_pc_inc;
                    w_we_nxt    = w_dec.is_store;
                    w_state_nxt = EXEC;
                end
            end
            default: begin
                w_exec      = w_dec.wr_a;
                w_we_nxt    = 1'b0;
                w_addr_nxt  = r_pc;
                w_state_nxt = FETCH;
            end
        endcase
        if (w_exec) begin
            w_a_nxt = w_alu_res;
            w_c_nxt = w_alu_cout;
            w_z_nxt = (w_alu_res == 8'h00);
            w_n_nxt = w_alu_res[7];
        end
    end

    assign bus.addr     = r_addr;
    assign bus.we       = r_we;
    assign bus.data_out = r_a;
    assign bus.sync     = (r_state == FETCH);
    assign a_out        = r_a;
    assign flags        = {r_n, r_z, r_c};
endmodule
`default_nettype wire

// File: tb/tb_u14_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_u14_cpu
//  Brief    : Self-checking bench for u14_cpu against an instruction-level model.
//  Revision : 1.0
// ============================================================================
module tb_u14_cpu;
    logic       clk;
    logic       rst;
    logic [7:0] a_out;
    logic [2:0] flags;

    u14_if #(.ADDR_W(16)) bus ();

    u14_cpu #(.ADDR_W(16), .RST_VEC(16'hFFF0)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .a_out (a_out),
        .flags (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] dm [0:65535];
    logic [7:0] mm [0:65535];

    assign bus.data_in = dm[bus.addr];

    int          wcnt = 0;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic        wbad = 1'b0;
    logic        prev_we = 1'b0;
    logic [15:0] prev_addr = 16'h0;

    always @(posedge clk) begin
        if (!rst && bus.we && bus.rdy) begin
            dm[bus.addr] <= bus.data_out;
            wcnt         <= wcnt + 1;
            waddr        <= bus.addr;
            wdata        <= bus.data_out;
        end
        if (bus.we && prev_we && bus.addr != prev_addr) wbad <= 1'b1;
        prev_we   <= bus.we;
        prev_addr <= bus.addr;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference state
    int ma, mc, mz, mn, mpc;

    task automatic model_reset();
        ma = 0; mc = 0; mz = 0; mn = 0; mpc = 16'hFFF0;
    endtask

    task automatic put(input int a, input int v);
        dm[a & 16'hFFFF] = v[7:0];
        mm[a & 16'hFFFF] = v[7:0];
    endtask

    task automatic model_step(output int cyc, output int st, output int ea);
        int op, p1, p2, m, npc, r;
        bit wr, tk;
        op = mm[mpc]; p1 = mm[(mpc + 1) & 16'hFFFF]; p2 = mm[(mpc + 2) & 16'hFFFF];
        st = 0; ea = 0; wr = 0; m = 0; cyc = 2; npc = mpc + 1;
        case (op)
            8'hA9, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49: begin m = p1; npc = mpc + 2; wr = 1; end
            8'hA5, 8'h65, 8'hE5, 8'h25, 8'h05, 8'h45: begin m = mm[p1]; cyc = 3; npc = mpc + 2; wr = 1; end
            8'hAD, 8'h6D, 8'hED, 8'h2D, 8'h0D, 8'h4D: begin m = mm[p2 * 256 + p1]; cyc = 4; npc = mpc + 3; wr = 1; end
            8'h85: begin st = 1; ea = p1; cyc = 3; npc = mpc + 2; end
            8'h8D: begin st = 1; ea = p2 * 256 + p1; cyc = 4; npc = mpc + 3; end
            8'h4C: begin cyc = 3; npc = p2 * 256 + p1; end
            8'h90, 8'hB0, 8'hD0, 8'hF0: begin
                case (op)
                    8'h90:   tk = (mc == 0);
                    8'hB0:   tk = (mc == 1);
                    8'hD0:   tk = (mz == 0);
                    default: tk = (mz == 1);
                endcase
                npc = mpc + 2 + (tk ? ((p1 >= 128) ? p1 - 256 : p1) : 0);
            end
            8'h18: mc = 0;
            8'h38: mc = 1;
            default: ;
        endcase
        if (wr) begin
            case (op / 16)
                4'hA: ma = m;
                4'h6: begin r = ma + m + mc; mc = (r > 255) ? 1 : 0; ma = r & 255; end
                4'hE: begin r = ma - m - (1 - mc); mc = (r >= 0) ? 1 : 0; ma = r & 255; end
                4'h2: ma = ma & m;
                4'h0: ma = ma | m;
                default: ma = ma ^ m;
            endcase
            mz = (ma == 0) ? 1 : 0;
            mn = (ma >= 128) ? 1 : 0;
        end
        if (st != 0) mm[ea] = ma[7:0];
        mpc = npc & 16'hFFFF;
    endtask

    task automatic run_instr(input bit rnd, input string tag);
        int cyc, st, ea, dcyc, w0;
        bit done;
        w0 = wcnt;
        model_step(cyc, st, ea);
        dcyc = 0; done = 0;
        for (int n = 0; n < 64 && !done; n++) begin
            bus.rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (bus.rdy) dcyc++;
            if (dcyc > 0 && bus.sync) done = 1;
        end
        bus.rdy = 1'b1;
        chk({tag, ".done"},  done, 1);
        chk({tag, ".cyc"},   dcyc, cyc);
        chk({tag, ".addr"},  bus.addr, mpc);
        chk({tag, ".a"},     a_out, ma);
        chk({tag, ".flags"}, flags, {mn[0], mz[0], mc[0]});
        chk({tag, ".wcnt"},  wcnt - w0, st);
        chk({tag, ".wbad"},  wbad, 0);
        if (st != 0) begin
            chk({tag, ".waddr"}, waddr, ea);
            chk({tag, ".wdata"}, wdata, ma);
            chk({tag, ".ram"},   dm[ea], mm[ea]);
        end
    endtask

    initial begin
        int edges;
        logic [7:0] ops [28];
        ops = '{8'hA9, 8'hA5, 8'hAD, 8'h85, 8'h8D, 8'h69, 8'h65, 8'h6D, 8'hE9, 8'hE5,
                8'hED, 8'h29, 8'h25, 8'h2D, 8'h09, 8'h05, 8'h0D, 8'h49, 8'h45, 8'h4D,
                8'h90, 8'hB0, 8'hD0, 8'hF0, 8'h18, 8'h38, 8'hEA, 8'h02};
        for (int i = 0; i < 65536; i++) put(i, $urandom_range(0, 255));

        // Directed program from the reset vector, wrapping through FFFF into 0000.
        put(16'hFFF0, 8'hA9); put(16'hFFF1, 8'h7F); put(16'hFFF2, 8'h69); put(16'hFFF3, 8'h01);
        put(16'hFFF4, 8'hA9); put(16'hFFF5, 8'h5A);
        put(16'hFFF6, 8'h8D); put(16'hFFF7, 8'h40); put(16'hFFF8, 8'h00);
        put(16'hFFF9, 8'h38); put(16'hFFFA, 8'hE5); put(16'hFFFB, 8'h10);
        put(16'hFFFC, 8'h18); put(16'hFFFD, 8'hE9); put(16'hFFFE, 8'h01);
        put(16'hFFFF, 8'h4C); put(16'h0000, 8'h00); put(16'h0001, 8'h02);
        put(16'h0010, 8'h5A);
        put(16'h0200, 8'hA9); put(16'h0201, 8'h00); put(16'h0202, 8'hD0); put(16'h0203, 8'h04);
        put(16'h0204, 8'hF0); put(16'h0205, 8'hFE);

        rst = 1'b1; bus.rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.addr", bus.addr, 16'hFFF0);
        chk("rst.we", bus.we, 0);
        chk("rst.sync", bus.sync, 1);
        chk("rst.a", a_out, 8'h00);
        chk("rst.flags", flags, 3'b000);
        rst = 1'b0;
        model_reset();

        run_instr(0, "lda7f");
        run_instr(0, "adc01");
        chk("adc.a80", a_out, 8'h80);
        chk("adc.flags", flags, 3'b100);
        chk("adc.next", bus.addr, 16'hFFF4);
        run_instr(0, "lda5a");
        run_instr(0, "sta40");
        chk("sta.ram", dm[16'h0040], 8'h5A);
        run_instr(0, "sec");
        run_instr(0, "sbczp");
        chk("sbczp.a", a_out, 8'h00);
        chk("sbczp.flags", flags, 3'b011);
        run_instr(0, "clc");
        run_instr(0, "sbcimm");
        chk("sbcimm.a", a_out, 8'hFE);
        chk("sbcimm.flags", flags, 3'b100);
        run_instr(0, "jmpwrap");
        chk("jmpwrap.addr", bus.addr, 16'h0200);
        run_instr(0, "lda00");
        run_instr(0, "bne");
        chk("bne.addr", bus.addr, 16'h0204);
        run_instr(0, "beq");
        chk("beq.addr", bus.addr, 16'h0204);

        // Replace the self-loop with JMP $1234 and stall it in the high-byte cycle.
        put(16'h0204, 8'h4C); put(16'h0205, 8'h34); put(16'h0206, 8'h12);
        put(16'h1234, 8'hA9); put(16'h1235, 8'hC3);
        put(16'h1236, 8'h8D); put(16'h1237, 8'h80); put(16'h1238, 8'h40);
        mpc = 16'h1234;
        edges = 0;
        repeat (2) begin @(negedge clk); edges++; end
        chk("jstall.addr0", bus.addr, 16'h0206);
        bus.rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); edges++;
            chk("jstall.addr", bus.addr, 16'h0206);
            chk("jstall.sync", bus.sync, 0);
        end
        bus.rdy = 1'b1;
        @(negedge clk); edges++;
        chk("jstall.tgt", bus.addr, 16'h1234);
        chk("jstall.sync1", bus.sync, 1);
        chk("jstall.edges", edges, 6);

        run_instr(0, "ldac3");
        repeat (3) @(negedge clk);
        chk("rstw.we1", bus.we, 1);
        chk("rstw.addr1", bus.addr, 16'h4080);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw.we0", bus.we, 0);
        chk("rstw.addr", bus.addr, 16'hFFF0);
        chk("rstw.a", a_out, 8'h00);
        rst = 1'b0;
        model_reset();

        // Random program at 0300 executed with random rdy stalls.
        put(16'hFFF0, 8'h4C); put(16'hFFF1, 8'h00); put(16'hFFF2, 8'h03);
        run_instr(0, "jmp300");
        begin
            int p;
            p = 16'h0300;
            for (int i = 0; i < 150; i++) begin
                logic [7:0] op;
                op = ops[$urandom_range(0, 27)];
                put(p, op); p++;
                if (op == 8'h90 || op == 8'hB0 || op == 8'hD0 || op == 8'hF0) begin
                    put(p, $urandom_range(0, 3)); p++;
                end else if (op[3:0] == 4'hD) begin
                    put(p, $urandom_range(0, 255)); put(p + 1, 8'h40); p += 2;
                end else if (op[3:0] == 4'h9 || op[3:0] == 4'h5) begin
                    put(p, $urandom_range(0, 255)); p++;
                end
            end
        end
        for (int i = 0; i < 150; i++) run_instr(1, $sformatf("rnd%0d", i));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
